// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/bubble constants,
// fetch FSM encodings, opcode constants and the Pipe1 {PC,IR} entry type.
package fetch_stage_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] NOP_IR_DEF   = 16'hF000;

  localparam logic [3:0] OP_BEQ = 4'hC;
  localparam logic [3:0] OP_JAL = 4'h8;
  localparam logic [3:0] OP_JLR = 4'h9;
  localparam logic [3:0] OP_NOP = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } fetch_entry_t;

  function automatic logic is_nop(input logic [15:0] ir);
    return ir[15:12] == OP_NOP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched {PC,IR} that returned while decode
// was stalled. Flush (redirect) and clear (drained into Pipe1) both empty it.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic        flush_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] data_o
);

  logic        valid_q;
  logic [31:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (flush_i || clear_i) begin
        valid_q <= 1'b0;
      end else if (load_i) begin
        valid_q <= 1'b1;
      end
      if (load_i && !flush_i) begin
        data_q <= data_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem request outstanding and
// fills the IF/ID register (Pipe1). Define FETCH_SKID_EN to keep a word that
// returns during a stall in a one-entry skid buffer instead of re-fetching it.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [15:0] NOP_IR   = NOP_IR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  output logic [15:0] toPipe1PC,
  output logic [15:0] toPipe1IR,
  output logic        toPipe1Valid,
  output logic [15:0] toPipe1PCp1,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a cycle with imem_req & imem_gnt; its
  // single response comes back later as one imem_rvalid pulse with imem_rdata.

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  p1_pc_q, p1_pc_d;
  logic [15:0]  p1_ir_q, p1_ir_d;
  logic         p1_valid_q, p1_valid_d;
  logic         hs;

  assign hs = imem_req && imem_gnt;

`ifdef FETCH_SKID_EN
  logic         skid_valid;
  logic         skid_load;
  logic         skid_clear;
  logic [31:0]  skid_data;
  fetch_entry_t skid_entry;

  assign skid_entry = fetch_entry_t'(skid_data);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .flush_i (redirect),
    .data_i  ({pc_q, imem_rdata}),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      p1_pc_q    <= 16'h0000;
      p1_ir_q    <= NOP_IR;
      p1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      p1_pc_q    <= p1_pc_d;
      p1_ir_q    <= p1_ir_d;
      p1_valid_q <= p1_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    // Decode consumes Pipe1 every unstalled cycle, so it becomes a bubble unless refilled.
    p1_pc_d    = p1_pc_q;
    p1_ir_d    = stall ? p1_ir_q : NOP_IR;
    p1_valid_d = stall ? p1_valid_q : 1'b0;
`ifdef FETCH_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = !stall;
`ifdef FETCH_SKID_EN
        if (!stall && skid_valid && !redirect) begin
          p1_pc_d    = skid_entry.pc;
          p1_ir_d    = skid_entry.ir;
          p1_valid_d = 1'b1;
          skid_clear = 1'b1;
        end
`endif
        if (hs) state_d = redirect ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? S_REQ : S_DISCARD;
        end else if (imem_rvalid) begin
          state_d = S_REQ;
          if (!stall) begin
            p1_pc_d    = pc_q;
            p1_ir_d    = imem_rdata;
            p1_valid_d = 1'b1;
            pc_d       = pc_q + 16'd1;
          end
`ifdef FETCH_SKID_EN
          else begin
            skid_load = 1'b1;
            pc_d      = pc_q + 16'd1;
          end
`endif
        end
      end
      S_DISCARD: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect outranks stall and any returning data.
    if (redirect) begin
      pc_d       = redirectPC;
      p1_pc_d    = p1_pc_q;
      p1_ir_d    = NOP_IR;
      p1_valid_d = 1'b0;
    end
  end

  assign imem_addr    = pc_q;
  assign toPipe1PC    = p1_pc_q;
  assign toPipe1IR    = p1_ir_q;
  assign toPipe1Valid = p1_valid_q;
  assign toPipe1PCp1  = p1_pc_q + 16'd1;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The memory model answers every handshake after
// `lat` cycles with word = addr + 16'h1000; expectations follow the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPC = 16'h0000;
  logic [15:0] toPipe1PC, toPipe1IR, toPipe1PCp1;
  logic        toPipe1Valid;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;
  int hs_count = 0;
  int hs_taken = 0;
  logic [15:0] hs_addr = 16'h0000;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [15:0] pend_addr = 16'h0000;
  logic [15:0] exp_q[$];

  fetch_stage dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirectPC(redirectPC),
    .toPipe1PC(toPipe1PC), .toPipe1IR(toPipe1IR), .toPipe1Valid(toPipe1Valid),
    .toPipe1PCp1(toPipe1PCp1), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
      hs_count = hs_count + 1;
      hs_addr  = imem_addr;
    end
  end

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (hs_count != hs_taken) begin
      hs_taken  = hs_count;
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = hs_addr;
    end
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend_addr + 16'h1000;
        pend        = 1'b0;
      end else begin
        pend_cnt = pend_cnt - 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (toPipe1Valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_redirect(input logic [15:0] target);
    redirect = 1'b1;
    redirectPC = target;
    tick();
    redirect = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (2) tick();
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_tests++; if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
    n_tests++; if (toPipe1PC !== 16'h0000) begin n_fail++; $display("FAIL rst_pc: got %h want 0000", toPipe1PC); end
    n_tests++; if (toPipe1IR !== 16'hF000) begin n_fail++; $display("FAIL rst_ir: got %h want F000", toPipe1IR); end
    n_tests++; if (toPipe1Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", toPipe1Valid); end
    n_tests++; if (toPipe1PCp1 !== 16'h0001) begin n_fail++; $display("FAIL rst_pcp1: got %h want 0001", toPipe1PCp1); end
    n_tests++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", dbg_state, S_IDLE); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] e;
    int seen;
    lat = 1;
    tick();
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL basic_first_req: got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr); end
    n_tests++; if (toPipe1Valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b want 0", toPipe1Valid); end
    exp_q = {16'h0000, 16'h0001, 16'h0002};
    seen = 0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      tick();
      if (toPipe1Valid === 1'b1) begin
        e = exp_q.pop_front();
        seen++;
        n_tests++; if (toPipe1PC !== e || toPipe1IR !== e + 16'h1000 || toPipe1PCp1 !== e + 16'h0001) begin
          n_fail++; $display("FAIL basic_seq: got pc=%h ir=%h pcp1=%h want pc=%h ir=%h", toPipe1PC, toPipe1IR, toPipe1PCp1, e, e + 16'h1000);
        end
      end
    end
    n_tests++; if (seen != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", seen); end
  endtask

  task automatic test_wrap();
    logic ok;
    do_redirect(16'hFFFF);
    wait_valid(ok);
    n_tests++; if (!ok || toPipe1PC !== 16'hFFFF || toPipe1IR !== 16'h0FFF) begin n_fail++; $display("FAIL wrap_ffff: got ok=%b pc=%h ir=%h want pc=FFFF ir=0FFF", ok, toPipe1PC, toPipe1IR); end
    n_tests++; if (toPipe1PCp1 !== 16'h0000) begin n_fail++; $display("FAIL wrap_pcp1: got %h want 0000", toPipe1PCp1); end
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr); end
    wait_valid(ok);
    n_tests++; if (!ok || toPipe1PC !== 16'h0000 || toPipe1IR !== 16'h1000) begin n_fail++; $display("FAIL wrap_next: got ok=%b pc=%h ir=%h want pc=0000 ir=1000", ok, toPipe1PC, toPipe1IR); end
  endtask

  task automatic test_redirect_wait();
    logic ok;
    lat = 3;
    tick();
    n_tests++; if (dbg_state !== S_WAIT) begin n_fail++; $display("FAIL redir_in_wait: got state %0d want %0d", dbg_state, S_WAIT); end
    do_redirect(16'h0040);
    n_tests++; if (toPipe1Valid !== 1'b0 || toPipe1IR !== 16'hF000) begin n_fail++; $display("FAIL redir_flush: got valid=%b ir=%h want valid=0 ir=F000", toPipe1Valid, toPipe1IR); end
    n_tests++; if (toPipe1PC !== 16'h0000) begin n_fail++; $display("FAIL redir_pc_keep: got %h want 0000", toPipe1PC); end
    n_tests++; if (dbg_state !== S_DISCARD || imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_discard: got state=%0d req=%b want state=%0d req=0", dbg_state, imem_req, S_DISCARD); end
    wait_req(ok);
    n_tests++; if (!ok || imem_addr !== 16'h0040) begin n_fail++; $display("FAIL redir_addr: got ok=%b addr=%h want 0040", ok, imem_addr); end
    wait_valid(ok);
    n_tests++; if (!ok || toPipe1PC !== 16'h0040 || toPipe1IR !== 16'h1040) begin n_fail++; $display("FAIL redir_first: got ok=%b pc=%h ir=%h want pc=0040 ir=1040", ok, toPipe1PC, toPipe1IR); end
  endtask

  task automatic test_stall();
    logic ok;
    logic found;
    lat = 2;
    do_redirect(16'h0004);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req === 1'b1 && imem_addr === 16'h0005) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL stall_reach5: got no request for 0005 want one"); end
    tick();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (toPipe1Valid !== 1'b0 || toPipe1PC !== 16'h0004 || toPipe1IR !== 16'hF000 || imem_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_hold%0d: got valid=%b pc=%h ir=%h req=%b want valid=0 pc=0004 ir=F000 req=0", i, toPipe1Valid, toPipe1PC, toPipe1IR, imem_req);
      end
      tick();
    end
    stall = 1'b0;
    #1;
`ifdef FETCH_SKID_EN
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin n_fail++; $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=0006", imem_req, imem_addr); end
    tick();
    n_tests++; if (toPipe1Valid !== 1'b1 || toPipe1PC !== 16'h0005 || toPipe1IR !== 16'h1005) begin n_fail++; $display("FAIL stall_skid_out: got valid=%b pc=%h ir=%h want valid=1 pc=0005 ir=1005", toPipe1Valid, toPipe1PC, toPipe1IR); end
`else
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL stall_refetch: got req=%b addr=%h want req=1 addr=0005", imem_req, imem_addr); end
    tick();
    n_tests++; if (toPipe1Valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_skid: got valid=%b want 0", toPipe1Valid); end
    wait_valid(ok);
    n_tests++; if (!ok || toPipe1PC !== 16'h0005 || toPipe1IR !== 16'h1005) begin n_fail++; $display("FAIL stall_refetch_out: got ok=%b pc=%h ir=%h want pc=0005 ir=1005", ok, toPipe1PC, toPipe1IR); end
`endif
  endtask

  task automatic test_redirect_stall();
    logic ok;
    stall = 1'b1;
    do_redirect(16'h0100);
    n_tests++; if (toPipe1Valid !== 1'b0 || toPipe1IR !== 16'hF000 || toPipe1PC !== 16'h0005 || toPipe1PCp1 !== 16'h0006) begin
      n_fail++; $display("FAIL rs_flush: got valid=%b ir=%h pc=%h pcp1=%h want valid=0 ir=F000 pc=0005 pcp1=0006", toPipe1Valid, toPipe1IR, toPipe1PC, toPipe1PCp1);
    end
    tick();
    n_tests++; if (toPipe1Valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rs_hold: got valid=%b req=%b want valid=0 req=0", toPipe1Valid, imem_req); end
    stall = 1'b0;
    #1;
    wait_req(ok);
    n_tests++; if (!ok || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL rs_addr: got ok=%b addr=%h want 0100", ok, imem_addr); end
    wait_valid(ok);
    n_tests++; if (!ok || toPipe1PC !== 16'h0100 || toPipe1IR !== 16'h1100) begin n_fail++; $display("FAIL rs_first: got ok=%b pc=%h ir=%h want pc=0100 ir=1100", ok, toPipe1PC, toPipe1IR); end
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    lat = 3;
    tick();
    tick();
    n_tests++; if (dbg_state !== S_WAIT) begin n_fail++; $display("FAIL mrst_in_wait: got state %0d want %0d", dbg_state, S_WAIT); end
    reset_n = 1'b0;
    #1;
    n_tests++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL mrst_now: got req=%b addr=%h state=%0d want req=0 addr=0000 state=0", imem_req, imem_addr, dbg_state); end
    n_tests++; if (toPipe1Valid !== 1'b0 || toPipe1IR !== 16'hF000 || toPipe1PC !== 16'h0000) begin n_fail++; $display("FAIL mrst_pipe: got valid=%b ir=%h pc=%h want valid=0 ir=F000 pc=0000", toPipe1Valid, toPipe1IR, toPipe1PC); end
    tick();
    reset_n = 1'b1;
    tick();
    n_tests++; if (toPipe1Valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL mrst_late_rvalid: got valid=%b req=%b addr=%h want valid=0 req=1 addr=0000", toPipe1Valid, imem_req, imem_addr); end
    wait_valid(ok);
    n_tests++; if (!ok || toPipe1PC !== 16'h0000 || toPipe1IR !== 16'h1000) begin n_fail++; $display("FAIL mrst_restart: got ok=%b pc=%h ir=%h want pc=0000 ir=1000", ok, toPipe1PC, toPipe1IR); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_redirect_wait();
    test_stall();
    test_redirect_stall();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
